complex_arith_unit: RTL

COMPLEX_ARITH_UNIT -- requirements
Module: complex_arith_unit

---
 rtl/complex_arith_unit_if.sv | 28 ++
 rtl/complex_arith_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/complex_arith_unit_if.sv
// rtl/complex_arith_unit_if.sv - request/response bundle for the complex multiply/divide unit
interface complex_arith_unit_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 1
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        op_mode_i;
  logic [3:0][WIDTH-1:0]       operands_i;
  logic [TAG_WIDTH-1:0]        tag_i;
  logic                        flush_i;
  logic [1:0][WIDTH-1:0]       result_o;
  logic [1:0]                  status_o;
  logic [TAG_WIDTH-1:0]        tag_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic                        busy_o;

  modport master (
    output in_valid_i, op_mode_i, operands_i, tag_i, flush_i, out_ready_i,
    input  in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_mode_i, operands_i, tag_i, flush_i, out_ready_i,
    output in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/complex_arith_unit.sv
// rtl/complex_arith_unit.sv - fixed-point complex multiply and bit-serial complex divide
module complex_arith_unit #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int TAG_WIDTH = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  complex_arith_unit_if.slave bus
);
  localparam int QBITS = 2*WIDTH + FRAC;
  localparam int PW    = 2*WIDTH + 1;
  localparam int SW    = QBITS + 1;
  localparam int CW    = $clog2(QBITS);
  localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PROD, DIV, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   op_a, op_b, op_c, op_d;
  logic                      mode_q;
  logic [TAG_WIDTH-1:0]      tag_q, tag_out_q;
  logic [PW-1:0]             den_q;
  logic [QBITS-1:0]          dvd_re_q, dvd_im_q;
  logic [PW-2:0]             rem_re_q, rem_im_q;
  logic                      neg_re_q, neg_im_q;
  logic [CW-1:0]             cnt_q;
  logic [1:0][WIDTH-1:0]     result_q;
  logic [1:0]                status_q;

  logic                      in_ready, accept, last_step;
  logic signed [PW-1:0]      ac, bd, ad, bc, cc, dd;
  logic signed [PW-1:0]      mul_re, mul_im, div_nr, div_ni, den;
  logic [PW-1:0]             abs_nr, abs_ni;
  logic [PW+QBITS-2:0]       step_re, step_im;
  logic [WIDTH:0]            sat_mre, sat_mim, sat_dre, sat_dim;

  function automatic logic signed [PW-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // One restoring step: shift the next dividend bit into the remainder, quotient bit enters at the bottom.
  function automatic logic [PW+QBITS-2:0] div_step(input logic [PW-2:0] rem,
                                                   input logic [QBITS-1:0] dvd,
                                                   input logic [PW-1:0] dv);
    logic [PW-1:0] trial;
    trial = {rem, dvd[QBITS-1]};
    if (trial >= dv) return {(PW-1)'(trial - dv), dvd[QBITS-2:0], 1'b1};
    return {trial[PW-2:0], dvd[QBITS-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH:0] saturate(input logic signed [SW-1:0] v);
    if (v > SMAX) return {1'b1, SMAX[WIDTH-1:0]};
    if (v < SMIN) return {1'b1, SMIN[WIDTH-1:0]};
    return {1'b0, v[WIDTH-1:0]};
  endfunction

  assign ac     = sx(op_a) * sx(op_c);
  assign bd     = sx(op_b) * sx(op_d);
  assign ad     = sx(op_a) * sx(op_d);
  assign bc     = sx(op_b) * sx(op_c);
  assign cc     = sx(op_c) * sx(op_c);
  assign dd     = sx(op_d) * sx(op_d);
  assign mul_re = ac - bd;
  assign mul_im = ad + bc;
  assign div_nr = ac + bd;
  assign div_ni = bc - ad;
  assign den    = cc + dd;
  assign abs_nr = div_nr[PW-1] ? -div_nr : div_nr;
  assign abs_ni = div_ni[PW-1] ? -div_ni : div_ni;

  assign step_re   = div_step(rem_re_q, dvd_re_q, den_q);
  assign step_im   = div_step(rem_im_q, dvd_im_q, den_q);
  assign last_step = (cnt_q == CW'(QBITS-1));

  always_comb begin
    sat_mre = saturate(SW'(mul_re >>> FRAC));
    sat_mim = saturate(SW'(mul_im >>> FRAC));
    sat_dre = saturate(neg_re_q ? -$signed({1'b0, step_re[QBITS-1:0]}) : $signed({1'b0, step_re[QBITS-1:0]}));
    sat_dim = saturate(neg_im_q ? -$signed({1'b0, step_im[QBITS-1:0]}) : $signed({1'b0, step_im[QBITS-1:0]}));
  end

  assign in_ready = !bus.flush_i && (state_q == IDLE || (state_q == DONE && bus.out_ready_i));
  assign accept   = bus.in_valid_i && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = PROD;
      PROD: begin
        if (bus.flush_i)                    state_d = IDLE;
        else if (!mode_q || den == '0)      state_d = DONE;
        else                                state_d = DIV;
      end
      DIV: begin
        if (bus.flush_i)                    state_d = IDLE;
        else if (last_step)                 state_d = DONE;
      end
      DONE: begin
        if (bus.flush_i)                    state_d = IDLE;
        else if (bus.out_ready_i)           state_d = accept ? PROD : IDLE;
      end
      default:                              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_d      <= '0;
      mode_q    <= 1'b0;
      tag_q     <= '0;
      tag_out_q <= '0;
      den_q     <= '0;
      dvd_re_q  <= '0;
      dvd_im_q  <= '0;
      rem_re_q  <= '0;
      rem_im_q  <= '0;
      neg_re_q  <= 1'b0;
      neg_im_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      status_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a   <= bus.operands_i[0];
        op_b   <= bus.operands_i[1];
        op_c   <= bus.operands_i[2];
        op_d   <= bus.operands_i[3];
        mode_q <= bus.op_mode_i;
        tag_q  <= bus.tag_i;
      end
      unique case (state_q)
        PROD: if (!bus.flush_i) begin
          if (!mode_q) begin
            result_q  <= {sat_mim[WIDTH-1:0], sat_mre[WIDTH-1:0]};
            status_q  <= {1'b0, sat_mre[WIDTH] | sat_mim[WIDTH]};
            tag_out_q <= tag_q;
          end else if (den == '0) begin
            result_q  <= {SMAX[WIDTH-1:0], SMAX[WIDTH-1:0]};
            status_q  <= 2'b10;
            tag_out_q <= tag_q;
          end else begin
            den_q    <= den;
            dvd_re_q <= QBITS'(abs_nr) << FRAC;
            dvd_im_q <= QBITS'(abs_ni) << FRAC;
            rem_re_q <= '0;
            rem_im_q <= '0;
            neg_re_q <= div_nr[PW-1];
            neg_im_q <= div_ni[PW-1];
            cnt_q    <= '0;
          end
        end
        DIV: if (!bus.flush_i) begin
          {rem_re_q, dvd_re_q} <= step_re;
          {rem_im_q, dvd_im_q} <= step_im;
          cnt_q                <= cnt_q + 1'b1;
          if (last_step) begin
            result_q  <= {sat_dim[WIDTH-1:0], sat_dre[WIDTH-1:0]};
            status_q  <= {1'b0, sat_dre[WIDTH] | sat_dim[WIDTH]};
            tag_out_q <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.result_o    = result_q;
  assign bus.status_o    = status_q;
  assign bus.tag_o       = tag_out_q;
endmodule
